// File: rtl/memory_access_stage_if.sv
// Data-cache request/response bus between the memory-access stage (master)
// and the data cache (slave).
interface memory_access_stage_if;
    // A request transfers on a rising edge where DCACHE_REQ_VALID and DCACHE_REQ_READY are both 1;
    // once VALID rises, WRITE/ADDR/WSTRB/WDATA stay stable until that edge. RESP_VALID has no ready.
    logic        DCACHE_REQ_VALID;
    logic        DCACHE_REQ_READY;
    logic        DCACHE_REQ_WRITE;
    logic [31:0] DCACHE_ADDR;
    logic [3:0]  DCACHE_WSTRB;
    logic [31:0] DCACHE_WDATA;
    logic        DCACHE_RESP_VALID;
    logic [31:0] DCACHE_RDATA;

    modport master (
        output DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_ADDR, DCACHE_WSTRB, DCACHE_WDATA,
        input  DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RDATA
    );

    modport slave (
        input  DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_ADDR, DCACHE_WSTRB, DCACHE_WDATA,
        output DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RDATA
    );
endinterface

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: turns loads/stores into data-cache requests and registers write-back.
// Optional macro MEMORY_ACCESS_STAGE_MISALIGN_TRAP_EN: misaligned accesses flag MISALIGNED_OUT instead of issuing.
module memory_access_stage (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CLEAR_MEMORY_STAGE,
    input  logic [31:0]                  ALU_IN,
    input  logic [4:0]                   RD_ADDRESS_IN,
    input  logic                         RD_WRITE_ENABLE_IN,
    input  logic [2:0]                   DATA_CACHE_LOAD_IN,
    input  logic [1:0]                   DATA_CACHE_STORE_IN,
    input  logic [31:0]                  DATA_CACHE_STORE_DATA_IN,
    memory_access_stage_if.master        dcache,
    output logic                         STALL_MEMORY_STAGE,
    output logic [4:0]                   RD_ADDRESS_OUT,
    output logic [31:0]                  RD_DATA_OUT,
    output logic                         RD_WRITE_ENABLE_OUT,
    output logic                         MISALIGNED_OUT,
    output logic [1:0]                   STATE_OUT
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [2:0] LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3, LD_LHU = 3'd4, LD_LW = 3'd5;
    localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;

    state_t      state;
    logic [1:0]  lane_q;
    logic [2:0]  load_q;
    logic [4:0]  rd_addr_q;
    logic        rd_we_q;
    logic        req_write_q;
    logic [31:0] req_addr_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] req_wdata_q;

    logic        in_is_load;
    logic        in_is_store;
    logic        in_bubble;
    logic        trap;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Codes 110/111 decode as "no load"; a load always wins over a simultaneous store.
    assign in_is_load  = (DATA_CACHE_LOAD_IN != 3'd0) && (DATA_CACHE_LOAD_IN <= LD_LW);
    assign in_is_store = (DATA_CACHE_STORE_IN != 2'd0);
    assign in_bubble   = CLEAR_MEMORY_STAGE || (!in_is_load && !in_is_store);

`ifdef MEMORY_ACCESS_STAGE_MISALIGN_TRAP_EN
    logic in_misaligned;
    always_comb begin
        in_misaligned = 1'b0;
        if (in_is_load) begin
            case (DATA_CACHE_LOAD_IN)
                LD_LH, LD_LHU: in_misaligned = ALU_IN[0];
                LD_LW:         in_misaligned = |ALU_IN[1:0];
                default:       in_misaligned = 1'b0;
            endcase
        end else begin
            case (DATA_CACHE_STORE_IN)
                ST_SH:   in_misaligned = ALU_IN[0];
                ST_SW:   in_misaligned = |ALU_IN[1:0];
                default: in_misaligned = 1'b0;
            endcase
        end
    end
    assign trap = in_misaligned;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (DATA_CACHE_STORE_IN)
            ST_SB: begin
                st_wstrb = 4'b0001 << ALU_IN[1:0];
                st_wdata = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
            end
            ST_SH: begin
                st_wstrb = 4'b0011 << {ALU_IN[1], 1'b0};
                st_wdata = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
            end
            ST_SW: begin
                st_wstrb = 4'b1111;
                st_wdata = DATA_CACHE_STORE_DATA_IN;
            end
            default: begin
                st_wstrb = 4'b0000;
                st_wdata = 32'h0;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    load_byte = dcache.DCACHE_RDATA[7:0];
            2'd1:    load_byte = dcache.DCACHE_RDATA[15:8];
            2'd2:    load_byte = dcache.DCACHE_RDATA[23:16];
            default: load_byte = dcache.DCACHE_RDATA[31:24];
        endcase
        load_half = lane_q[1] ? dcache.DCACHE_RDATA[31:16] : dcache.DCACHE_RDATA[15:0];
        case (load_q)
            LD_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LD_LBU:  load_data = {24'h0, load_byte};
            LD_LH:   load_data = {{16{load_half[15]}}, load_half};
            LD_LHU:  load_data = {16'h0, load_half};
            default: load_data = dcache.DCACHE_RDATA;
        endcase
    end

    assign STALL_MEMORY_STAGE      = (state != IDLE);
    assign STATE_OUT               = state;
    assign dcache.DCACHE_REQ_VALID = (state == REQ);
    assign dcache.DCACHE_REQ_WRITE = req_write_q;
    assign dcache.DCACHE_ADDR      = req_addr_q;
    assign dcache.DCACHE_WSTRB     = req_wstrb_q;
    assign dcache.DCACHE_WDATA     = req_wdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state               <= IDLE;
            lane_q              <= 2'd0;
            load_q              <= 3'd0;
            rd_addr_q           <= 5'd0;
            rd_we_q             <= 1'b0;
            req_write_q         <= 1'b0;
            req_addr_q          <= 32'h0;
            req_wstrb_q         <= 4'b0000;
            req_wdata_q         <= 32'h0;
            RD_ADDRESS_OUT      <= 5'd0;
            RD_DATA_OUT         <= 32'h0;
            RD_WRITE_ENABLE_OUT <= 1'b0;
            MISALIGNED_OUT      <= 1'b0;
        end else begin
            RD_WRITE_ENABLE_OUT <= 1'b0;
            MISALIGNED_OUT      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_bubble) begin
                        RD_DATA_OUT         <= ALU_IN;
                        RD_ADDRESS_OUT      <= RD_ADDRESS_IN;
                        RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN && !CLEAR_MEMORY_STAGE;
                    end else if (trap) begin
                        MISALIGNED_OUT <= 1'b1;
                    end else begin
                        lane_q      <= ALU_IN[1:0];
                        load_q      <= in_is_load ? DATA_CACHE_LOAD_IN : 3'd0;
                        rd_addr_q   <= RD_ADDRESS_IN;
                        rd_we_q     <= RD_WRITE_ENABLE_IN;
                        req_write_q <= !in_is_load;
                        req_addr_q  <= {ALU_IN[31:2], 2'b00};
                        req_wstrb_q <= in_is_load ? 4'b0000 : st_wstrb;
                        req_wdata_q <= in_is_load ? 32'h0 : st_wdata;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (dcache.DCACHE_REQ_READY) begin
                        state <= req_write_q ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (dcache.DCACHE_RESP_VALID) begin
                        RD_DATA_OUT         <= load_data;
                        RD_ADDRESS_OUT      <= rd_addr_q;
                        RD_WRITE_ENABLE_OUT <= rd_we_q;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed table-driven bench for memory_access_stage; expectations follow
// MEMORY_ACCESS_STAGE_MISALIGN_TRAP_EN when that macro is defined.
module tb_memory_access_stage;
    localparam int K_BUB  = 0;
    localparam int K_ST   = 1;
    localparam int K_LD   = 2;
    localparam int K_TRAP = 3;

    typedef struct {
        string       name;
        logic        clear;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          kind;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] sdata;
    logic        stall;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;
    logic        rd_we_out;
    logic        misaligned;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    memory_access_stage_if dc_if ();

    memory_access_stage dut (
        .CLK                      (clk),
        .RESET                    (reset),
        .CLEAR_MEMORY_STAGE       (clear),
        .ALU_IN                   (alu),
        .RD_ADDRESS_IN            (rd),
        .RD_WRITE_ENABLE_IN       (we),
        .DATA_CACHE_LOAD_IN       (ld),
        .DATA_CACHE_STORE_IN      (st),
        .DATA_CACHE_STORE_DATA_IN (sdata),
        .dcache                   (dc_if),
        .STALL_MEMORY_STAGE       (stall),
        .RD_ADDRESS_OUT           (rd_addr_out),
        .RD_DATA_OUT              (rd_data_out),
        .RD_WRITE_ENABLE_OUT      (rd_we_out),
        .MISALIGNED_OUT           (misaligned),
        .STATE_OUT                (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        clear = 1'b0; alu = 32'h0; rd = 5'd0; we = 1'b0;
        ld = 3'd0; st = 2'd0; sdata = 32'h0;
    endtask

    function automatic vec_t mk(input string name, input logic c, input logic [31:0] a,
                                input logic [4:0] r, input logic w, input logic [2:0] l,
                                input logic [1:0] s, input logic [31:0] sd, input logic [31:0] rdt,
                                input int k, input logic [31:0] ea, input logic [3:0] es,
                                input logic [31:0] ew, input logic [31:0] ed, input logic ewe);
        vec_t v;
        v.name = name; v.clear = c; v.alu = a; v.rd = r; v.we = w; v.ld = l; v.st = s;
        v.sdata = sd; v.rdata = rdt; v.kind = k; v.e_addr = ea; v.e_wstrb = es;
        v.e_wdata = ew; v.e_data = ed; v.e_we = ewe;
        return v;
    endfunction

    // One operation with a zero-wait cache: inputs at cycle T, checks from T+1 on.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        clear = v.clear; alu = v.alu; rd = v.rd; we = v.we; ld = v.ld; st = v.st;
        sdata = v.sdata; dc_if.DCACHE_RDATA = v.rdata;
        @(negedge clk);
        set_idle();
        case (v.kind)
            K_BUB: begin
                check({v.name, " rd_data"}, rd_data_out, v.e_data);
                check({v.name, " rd_addr"}, {27'h0, rd_addr_out}, {27'h0, v.rd});
                check({v.name, " we"}, {31'h0, rd_we_out}, {31'h0, v.e_we});
                check({v.name, " stall"}, {31'h0, stall}, 32'h0);
                check({v.name, " misaligned"}, {31'h0, misaligned}, 32'h0);
            end
            K_TRAP: begin
                check({v.name, " misaligned"}, {31'h0, misaligned}, 32'h1);
                check({v.name, " we"}, {31'h0, rd_we_out}, 32'h0);
                check({v.name, " req_valid"}, {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h0);
                check({v.name, " stall"}, {31'h0, stall}, 32'h0);
            end
            default: begin
                check({v.name, " req_valid"}, {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h1);
                check({v.name, " stall"}, {31'h0, stall}, 32'h1);
                check({v.name, " addr"}, dc_if.DCACHE_ADDR, v.e_addr);
                check({v.name, " write"}, {31'h0, dc_if.DCACHE_REQ_WRITE}, (v.kind == K_ST) ? 32'h1 : 32'h0);
                check({v.name, " we_busy"}, {31'h0, rd_we_out}, 32'h0);
                check({v.name, " misaligned"}, {31'h0, misaligned}, 32'h0);
                if (v.kind == K_ST) begin
                    check({v.name, " wstrb"}, {28'h0, dc_if.DCACHE_WSTRB}, {28'h0, v.e_wstrb});
                    check({v.name, " wdata"}, dc_if.DCACHE_WDATA, v.e_wdata);
                end
                dc_if.DCACHE_REQ_READY = 1'b1;
                @(negedge clk);
                dc_if.DCACHE_REQ_READY = 1'b0;
                if (v.kind == K_ST) begin
                    check({v.name, " state_idle"}, {30'h0, state_out}, 32'h0);
                    check({v.name, " we_store"}, {31'h0, rd_we_out}, 32'h0);
                end else begin
                    check({v.name, " state_wait"}, {30'h0, state_out}, 32'h2);
                    check({v.name, " req_dropped"}, {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h0);
                    dc_if.DCACHE_RESP_VALID = 1'b1;
                    @(negedge clk);
                    dc_if.DCACHE_RESP_VALID = 1'b0;
                    check({v.name, " rd_data"}, rd_data_out, v.e_data);
                    check({v.name, " rd_addr"}, {27'h0, rd_addr_out}, {27'h0, v.rd});
                    check({v.name, " we"}, {31'h0, rd_we_out}, {31'h0, v.e_we});
                    check({v.name, " state_done"}, {30'h0, state_out}, 32'h0);
                end
            end
        endcase
    endtask

    initial begin
`ifdef MEMORY_ACCESS_STAGE_MISALIGN_TRAP_EN
        localparam int K_MIS = K_TRAP;
`else
        localparam int K_MIS = K_LD;
`endif
        set_idle();
        reset = 1'b1;
        dc_if.DCACHE_REQ_READY = 1'b0;
        dc_if.DCACHE_RESP_VALID = 1'b0;
        dc_if.DCACHE_RDATA = 32'h0;

        // name clr alu rd we ld st sdata rdata kind addr wstrb wdata data we
        vecs.push_back(mk("alu_pass", 0, 32'h0000_1234, 5, 1, 0, 0, 0, 0, K_BUB, 0, 0, 0, 32'h0000_1234, 1));
        vecs.push_back(mk("clear", 1, 32'hDEAD_BEEF, 7, 1, 5, 0, 0, 0, K_BUB, 0, 0, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("lb_neg", 0, 32'h0000_0103, 3, 1, 1, 0, 0, 32'h80FF_00FF, K_LD, 32'h100, 0, 0, 32'hFFFF_FF80, 1));
        vecs.push_back(mk("lbu", 0, 32'h0000_0103, 3, 1, 2, 0, 0, 32'h80FF_00FF, K_LD, 32'h100, 0, 0, 32'h0000_0080, 1));
        vecs.push_back(mk("lh_hi", 0, 32'h0000_0202, 6, 1, 3, 0, 0, 32'h8001_7FFF, K_LD, 32'h200, 0, 0, 32'hFFFF_8001, 1));
        vecs.push_back(mk("lhu_lo", 0, 32'h0000_0200, 6, 1, 4, 0, 0, 32'h8001_F00F, K_LD, 32'h200, 0, 0, 32'h0000_F00F, 1));
        vecs.push_back(mk("lw", 0, 32'h0000_0300, 8, 1, 5, 0, 0, 32'hCAFE_BABE, K_LD, 32'h300, 0, 0, 32'hCAFE_BABE, 1));
        vecs.push_back(mk("lb_pos", 0, 32'h0000_0101, 2, 1, 1, 0, 0, 32'h1234_5678, K_LD, 32'h100, 0, 0, 32'h0000_0056, 1));
        vecs.push_back(mk("sb", 0, 32'h0000_0102, 1, 1, 0, 1, 32'h0000_00AB, 0, K_ST, 32'h100, 4'b0100, 32'hABAB_ABAB, 0, 0));
        vecs.push_back(mk("sh_hi", 0, 32'h0000_0402, 1, 0, 0, 2, 32'h1234_BEEF, 0, K_ST, 32'h400, 4'b1100, 32'hBEEF_BEEF, 0, 0));
        vecs.push_back(mk("sw", 0, 32'h0000_0500, 1, 0, 0, 3, 32'h1122_3344, 0, K_ST, 32'h500, 4'b1111, 32'h1122_3344, 0, 0));
        vecs.push_back(mk("ld_wins", 0, 32'h0000_0600, 12, 1, 5, 3, 32'hFFFF_FFFF, 32'h0BAD_F00D, K_LD, 32'h600, 0, 0, 32'h0BAD_F00D, 1));
        vecs.push_back(mk("ld_code6", 0, 32'h0000_0077, 9, 1, 6, 0, 0, 0, K_BUB, 0, 0, 0, 32'h0000_0077, 1));
        vecs.push_back(mk("lw_we0", 0, 32'h0000_0700, 4, 0, 5, 0, 0, 32'h2468_ACE0, K_LD, 32'h700, 0, 0, 32'h2468_ACE0, 0));
        vecs.push_back(mk("lw_misal", 0, 32'h0000_0102, 13, 1, 5, 0, 0, 32'h55AA_55AA, K_MIS, 32'h100, 0, 0, 32'h55AA_55AA, 1));
        vecs.push_back(mk("lh_misal", 0, 32'h0000_0203, 14, 1, 3, 0, 0, 32'h8000_0000, K_MIS, 32'h200, 0, 0, 32'hFFFF_8000, 1));

        repeat (2) @(negedge clk);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset req_valid", {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h0);
        check("reset rd_data", rd_data_out, 32'h0);
        check("reset we", {31'h0, rd_we_out}, 32'h0);
        check("reset state", {30'h0, state_out}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Store held by a slow cache: request fields stable, stall high, no write-back.
        @(negedge clk);
        alu = 32'h0000_0102; st = 2'd1; sdata = 32'h0000_00AB; rd = 5'd3; we = 1'b1;
        @(negedge clk);
        set_idle();
        for (int c = 0; c < 3; c++) begin
            check("sb_hold req_valid", {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h1);
            check("sb_hold addr", dc_if.DCACHE_ADDR, 32'h100);
            check("sb_hold wstrb", {28'h0, dc_if.DCACHE_WSTRB}, 32'h4);
            check("sb_hold wdata", dc_if.DCACHE_WDATA, 32'hABAB_ABAB);
            check("sb_hold write", {31'h0, dc_if.DCACHE_REQ_WRITE}, 32'h1);
            check("sb_hold stall", {31'h0, stall}, 32'h1);
            check("sb_hold we", {31'h0, rd_we_out}, 32'h0);
            @(negedge clk);
        end
        dc_if.DCACHE_REQ_READY = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_REQ_READY = 1'b0;
        check("sb_hold done stall", {31'h0, stall}, 32'h0);
        check("sb_hold done we", {31'h0, rd_we_out}, 32'h0);

        // LH then LW back to back: the LW is held and issues two cycles after the LH response.
        @(negedge clk);
        alu = 32'h0000_0200; ld = 3'd3; rd = 5'd10; we = 1'b1;
        @(negedge clk);
        alu = 32'h0000_0204; ld = 3'd5; rd = 5'd11; we = 1'b1;
        check("b2b lh req", {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h1);
        dc_if.DCACHE_REQ_READY = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_REQ_READY = 1'b0;
        check("b2b lh wait stall", {31'h0, stall}, 32'h1);
        dc_if.DCACHE_RDATA = 32'h0000_9ABC;
        dc_if.DCACHE_RESP_VALID = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_RESP_VALID = 1'b0;
        check("b2b lh data", rd_data_out, 32'hFFFF_9ABC);
        check("b2b lh rd", {27'h0, rd_addr_out}, 32'd10);
        check("b2b lh we", {31'h0, rd_we_out}, 32'h1);
        check("b2b lw not yet", {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h0);
        @(negedge clk);
        set_idle();
        check("b2b lw req", {31'h0, dc_if.DCACHE_REQ_VALID}, 32'h1);
        check("b2b lw addr", dc_if.DCACHE_ADDR, 32'h204);
        check("b2b lw we_busy", {31'h0, rd_we_out}, 32'h0);
        dc_if.DCACHE_REQ_READY = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_REQ_READY = 1'b0;
        dc_if.DCACHE_RDATA = 32'h1357_9BDF;
        dc_if.DCACHE_RESP_VALID = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_RESP_VALID = 1'b0;
        check("b2b lw data", rd_data_out, 32'h1357_9BDF);
        check("b2b lw rd", {27'h0, rd_addr_out}, 32'd11);
        check("b2b lw we", {31'h0, rd_we_out}, 32'h1);

        // Reset during WAIT abandons the load; a late response writes nothing.
        @(negedge clk);
        alu = 32'h0000_0800; ld = 3'd5; rd = 5'd20; we = 1'b1;
        @(negedge clk);
        set_idle();
        dc_if.DCACHE_REQ_READY = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_REQ_READY = 1'b0;
        check("rst_wait state", {30'h0, state_out}, 32'h2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait state_idle", {30'h0, state_out}, 32'h0);
        check("rst_wait stall", {31'h0, stall}, 32'h0);
        check("rst_wait rd_data", rd_data_out, 32'h0);
        check("rst_wait rd_addr", {27'h0, rd_addr_out}, 32'h0);
        check("rst_wait addr", dc_if.DCACHE_ADDR, 32'h0);
        dc_if.DCACHE_RDATA = 32'hFFFF_FFFF;
        dc_if.DCACHE_RESP_VALID = 1'b1;
        @(negedge clk);
        dc_if.DCACHE_RESP_VALID = 1'b0;
        check("rst_wait late resp we", {31'h0, rd_we_out}, 32'h0);
        check("rst_wait late resp state", {30'h0, state_out}, 32'h0);
        check("rst_wait late resp data", rd_data_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline memory-access stage that sits directly downstream of the execution stage and consumes its registered outputs: ALU result, load/store codes, store data and destination-register controls. Loads and stores are turned into a valid/ready request to the data cache, with byte-lane steering and sign/zero extension. The stage holds the execution stage stalled while an access is in flight. It registers the final write-back data, destination address and write enable toward the write-back stage.

## Interface
- HIGH, 1'b1, active level of all control inputs and outputs
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- CLEAR_MEMORY_STAGE  in  1  treat the current input as a bubble; ignored while busy
- ALU_IN  in  32  execution-stage ALU result; this is the memory address for loads and stores
- RD_ADDRESS_IN  in  5  destination register
- RD_WRITE_ENABLE_IN  in  1  destination write enable
- DATA_CACHE_LOAD_IN  in  3  load code: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110 and 111 are treated as none
- DATA_CACHE_STORE_IN  in  2  store code: 00 none, 01 SB, 10 SH, 11 SW
- DATA_CACHE_STORE_DATA_IN  in  32  store source data
- DCACHE_REQ_VALID  out  1  request valid
- DCACHE_REQ_READY  in  1  cache accepts the request
- DCACHE_REQ_WRITE  out  1  1 = store, 0 = load
- DCACHE_ADDR  out  32  word-aligned address
- DCACHE_WSTRB  out  4  byte-lane write strobes
- DCACHE_WDATA  out  32  lane-replicated store data
- DCACHE_RESP_VALID  in  1  load data valid
- DCACHE_RDATA  in  32  load data word
- STALL_MEMORY_STAGE  out  1  holds the execution stage
- RD_ADDRESS_OUT  out  5  registered destination register
- RD_DATA_OUT  out  32  registered write-back data
- RD_WRITE_ENABLE_OUT  out  1  registered write enable
- MISALIGNED_OUT  out  1  registered one-cycle misalignment flag

## Operation
- State machine states: IDLE, REQ, WAIT.
- STALL_MEMORY_STAGE = (state != IDLE). It is combinational from the state register.
- In IDLE, the input is classified on each edge:
  - **Bubble:** CLEAR is asserted, or both load and store codes are none. The ALU_IN, RD_ADDRESS_IN and RD_WRITE_ENABLE_IN fields are registered to the outputs; RD_WRITE_ENABLE_OUT is forced to 0 on CLEAR.
  - **Load or store:** the address, code, data and RD fields are latched internally, and the state moves to REQ. RD_WRITE_ENABLE_OUT is 0 for that cycle.
  - **Load and store both non-none:** the load wins and the store is discarded.
- In REQ:
  - DCACHE_REQ_VALID=1. The address, strobes and data are driven from the latched fields and stay stable until READY.
  - A store with READY goes to IDLE; there is no write-back.
  - A load with READY goes to WAIT.
- In WAIT:
  - On DCACHE_RESP_VALID, the extracted data is registered to RD_DATA_OUT, the latched RD address is registered, RD_WRITE_ENABLE_OUT is set to the latched enable, and the state goes to IDLE.
  - DCACHE_RESP_VALID in IDLE or REQ is ignored.
- Address rule: DCACHE_ADDR = {addr[31:2], 2'b00}.
- Store lanes:
  - SB: WSTRB = 0001 << addr[1:0]; WDATA = byte replicated ×4.
  - SH: WSTRB = 0011 << {addr[1], 0}; WDATA = halfword replicated ×2.
  - SW: WSTRB = 1111; WDATA = the data unchanged.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- Misaligned access: a halfword access with addr[0]=1, or a word access with addr[1:0] != 0.

## Timing
- Reset values: state IDLE; all outputs 0, including DCACHE_REQ_VALID and STALL.
- Reset mid-operation abandons the access: the state is IDLE after the edge, and a later RESP_VALID is ignored.
- The execution stage advances in the capture cycle (STALL is still 0) and is then held during REQ and WAIT. The held instruction is processed in the first IDLE cycle after completion.
- Latency is measured with the operation present at the input in cycle T:
  - Bubble or ALU operation: outputs valid at T+1.
  - Load with zero-wait READY and RESP: REQ_VALID at T+1, WAIT at T+2, RESP at T+2, RD outputs at T+3.
  - Store with zero-wait READY: REQ_VALID at T+1, IDLE at T+2.
- RESP is never expected in the same cycle as the accepting READY.
- RD_WRITE_ENABLE_OUT is 0 in every cycle that does not complete an operation.

## Configuration
- MEMORY_ACCESS_STAGE_MISALIGN_TRAP_EN
  - Defined: a misaligned access issues no request and does not enter REQ. MISALIGNED_OUT=1 for one cycle at T+1, and RD_WRITE_ENABLE_OUT=0.
  - Undefined: the low address bits are ignored, giving a halfword at lane addr[1] and a word at lane 0. MISALIGNED_OUT is tied to 0.

## Test plan
- ALU_IN=0x00001234, RD=5, WE=1, no load or store → T+1: RD_DATA_OUT=0x00001234, RD_ADDRESS_OUT=5, WE=1; STALL stays 0.
- LB at 0x00000103 with RDATA=0x80FF00FF and READY/RESP immediate → DCACHE_ADDR=0x00000100; T+3: RD_DATA_OUT=0xFFFFFF80. The same access as LBU gives 0x00000080.
- SB at 0x00000102 with data 0x000000AB and READY low for 3 cycles:
  - REQ_VALID, ADDR=0x100, WSTRB=0100, WDATA=0xABABABAB and WRITE=1 are held stable.
  - STALL is 1 for the whole wait.
  - RD_WRITE_ENABLE_OUT is never 1.
- LH at 0x200 followed by LW at 0x204:
  - The second load is held during the first.
  - Its REQ_VALID follows the first load's completion by exactly 2 cycles.
  - Both RD writes appear in order.
- RESET asserted during WAIT → next cycle: all outputs 0, state IDLE; a RESP_VALID pulse one cycle later produces no write.
- LW at 0x00000102:
  - With the macro: MISALIGNED_OUT=1 at T+1 and no REQ_VALID.
  - Without the macro: the request goes to ADDR=0x100, and RD_DATA_OUT equals RDATA.
